// File: rtl/dmem_sram_resp.sv
// Memory-side responder for the core's data-memory valid/ready port.
// Word-organised SRAM with byte-strobe writes and a fixed access latency.
module dmem_sram_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dmem_valid_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wstrb_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o,
  output logic        dmem_err_o
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic        LAT_ZERO = 1'(LATENCY == 0);
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic           ready_q;
  logic           err_q;
  logic [31:0]    rdata_q;
  logic           cap_we_q;
  logic           cap_in_range_q;
  logic [AW-1:0]  cap_idx_q;
  logic [31:0]    cap_wdata_q;
  logic [3:0]     cap_wstrb_q;
  logic [31:0]    mem_q [DEPTH_WORDS];

  logic [31:0]    off_s;
  logic           req_we_s;
  logic           req_in_range_s;
  logic [AW-1:0]  req_idx_s;
  logic [31:0]    req_wdata_s;
  logic [3:0]     req_wstrb_s;
  logic           enter_resp_s;
  logic           commit_s;

  // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both bounds.
  assign off_s = dmem_addr_i - BASE_ADDR;

  // Request fields: live inputs while IDLE (zero-latency path), captured copies afterwards.
  always_comb begin
    if (state_q == ST_IDLE) begin
      req_we_s       = dmem_we_i;
      req_in_range_s = (off_s < SPAN);
      req_idx_s      = off_s[AW+1:2];
      req_wdata_s    = dmem_wdata_i;
      req_wstrb_s    = dmem_wstrb_i;
    end else begin
      req_we_s       = cap_we_q;
      req_in_range_s = cap_in_range_q;
      req_idx_s      = cap_idx_q;
      req_wdata_s    = cap_wdata_q;
      req_wstrb_s    = cap_wstrb_q;
    end
  end

  // Flags the clock edge that moves the FSM into RESP.
  always_comb begin
    case (state_q)
      ST_IDLE: enter_resp_s = dmem_valid_i & LAT_ZERO;
      ST_WAIT: enter_resp_s = (cnt_q == 4'd0);
      default: enter_resp_s = 1'b0;
    endcase
  end

  assign commit_s = enter_resp_s & req_we_s & req_in_range_s;

  // Storage array: no reset, byte-lane writes committed on the edge entering RESP.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb_s[b]) begin
          mem_q[req_idx_s][8*b +: 8] <= req_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Handshake FSM with registered response outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      ready_q        <= 1'b0;
      err_q          <= 1'b0;
      rdata_q        <= 32'h0;
      cap_we_q       <= 1'b0;
      cap_in_range_q <= 1'b0;
      cap_idx_q      <= '0;
      cap_wdata_q    <= 32'h0;
      cap_wstrb_q    <= 4'h0;
    end else begin
      ready_q <= enter_resp_s;
      err_q   <= enter_resp_s & ~req_in_range_s;
      rdata_q <= (enter_resp_s && !req_we_s && req_in_range_s) ? mem_q[req_idx_s] : 32'h0;
      case (state_q)
        ST_IDLE: begin
          if (dmem_valid_i) begin
            cap_we_q       <= req_we_s;
            cap_in_range_q <= req_in_range_s;
            cap_idx_q      <= req_idx_s;
            cap_wdata_q    <= req_wdata_s;
            cap_wstrb_q    <= req_wstrb_s;
            cnt_q          <= CNT_INIT;
            state_q        <= LAT_ZERO ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem_ready_o = ready_q;
  assign dmem_err_o   = err_q;
  assign dmem_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_sram_resp.sv
// Self-checking bench for dmem_sram_resp: three instances with LATENCY 1, 0 and 3.
module tb_dmem_sram_resp;

  logic        clk;
  logic        rst_n;
  logic        valid [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        err   [3];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: LATENCY=1 full depth; 1: LATENCY=0; 2: LATENCY=3 (both 16 words).
  dmem_sram_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_n_i(rst_n), .dmem_valid_i(valid[0]), .dmem_we_i(we[0]),
    .dmem_addr_i(addr[0]), .dmem_wdata_i(wdata[0]), .dmem_wstrb_i(wstrb[0]),
    .dmem_rdata_o(rdata[0]), .dmem_ready_o(ready[0]), .dmem_err_o(err[0]));
  dmem_sram_resp #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(0)) u_l0 (
    .clk_i(clk), .rst_n_i(rst_n), .dmem_valid_i(valid[1]), .dmem_we_i(we[1]),
    .dmem_addr_i(addr[1]), .dmem_wdata_i(wdata[1]), .dmem_wstrb_i(wstrb[1]),
    .dmem_rdata_o(rdata[1]), .dmem_ready_o(ready[1]), .dmem_err_o(err[1]));
  dmem_sram_resp #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_n_i(rst_n), .dmem_valid_i(valid[2]), .dmem_we_i(we[2]),
    .dmem_addr_i(addr[2]), .dmem_wdata_i(wdata[2]), .dmem_wstrb_i(wstrb[2]),
    .dmem_rdata_o(rdata[2]), .dmem_ready_o(ready[2]), .dmem_err_o(err[2]));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] mdl [1024];

  function automatic int lat_of(input int n);
    return (n == 0) ? 1 : ((n == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at #1 after a posedge; returns at #1 after the posedge ending the response.
  task automatic txn(input int n, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic e, output int cyc);
    valid[n] = 1'b1; we[n] = w; addr[n] = a; wdata[n] = d; wstrb[n] = s;
    cyc = 0; rd = 32'h0; e = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready[n]) begin
        cyc = k; rd = rdata[n]; e = err[n];
        break;
      end
    end
    @(posedge clk); #1;
    valid[n] = 1'b0; we[n] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          cyc;
    logic [11:0] obs, expv;
    logic        saw;

    tbl[0]  = '{1'b1, 32'h0000_1000, 32'hA5A5_1234, 4'hF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'hF, 32'hA5A5_1234, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_1004, 32'h1111_1111, 4'hF, 32'h0000_0000, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_1004, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_1004, 32'h0000_0000, 4'h0, 32'h11BB_11DD, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    tbl[6]  = '{1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b1};
    tbl[7]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'h0, 32'hA5A5_1234, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_1FFC, 32'h0BAD_F00D, 4'hF, 32'h0000_0000, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_1FFC, 32'h0000_0000, 4'h0, 32'h0BAD_F00D, 1'b0};
    tbl[10] = '{1'b1, 32'h0000_1002, 32'h0000_00FF, 4'h1, 32'h0000_0000, 1'b0};
    tbl[11] = '{1'b0, 32'h0000_1003, 32'h0000_0000, 4'h0, 32'hA5A5_12FF, 1'b0};
    tbl[12] = '{1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
    tbl[13] = '{1'b0, 32'h0000_1004, 32'h0000_0000, 4'h0, 32'h11BB_11DD, 1'b0};
    tbl[14] = '{1'b0, 32'h0000_2000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    tbl[15] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1};

    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      valid[n] = 1'b0; we[n] = 1'b0; addr[n] = 32'h0; wdata[n] = 32'h0; wstrb[n] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      chk("reset_ready", {31'h0, ready[n]}, 32'h0);
      chk("reset_err",   {31'h0, err[n]},   32'h0);
      chk("reset_rdata", rdata[n],          32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table on the LATENCY=1 instance.
    for (int i = 0; i < 16; i++) begin
      txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, e, cyc);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'h0, e}, {31'h0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_latency", i), 32'(cyc), 32'd3);
    end

    // Back-to-back requests: ready must pulse once every LATENCY+2 cycles.
    for (int n = 1; n < 3; n++) begin
      valid[n] = 1'b1; we[n] = 1'b1; addr[n] = 32'h0000_1000; wdata[n] = 32'h0; wstrb[n] = 4'h0;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        obs[k-1]  = ready[n];
        expv[k-1] = ((k % (lat_of(n) + 2)) == 0);
      end
      @(posedge clk); #1;
      valid[n] = 1'b0; we[n] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk($sformatf("b2b_pulses_lat%0d", lat_of(n)), {20'h0, obs}, {20'h0, expv});
    end

    // Reset in WAIT drops an uncommitted write; the old word survives.
    txn(2, 1'b1, 32'h0000_1008, 32'h1234_5678, 4'hF, rd, e, cyc);
    chk("rst_pre_latency", 32'(cyc), 32'd5);
    valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h0000_1008; wdata[2] = 32'hFFFF_FFFF; wstrb[2] = 4'hF;
    saw = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw = saw | ready[2];
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    valid[2] = 1'b0; we[2] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw = saw | ready[2];
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      saw = saw | ready[2];
    end
    chk("rst_no_ready", {31'h0, saw}, 32'h0);
    @(posedge clk); #1;
    txn(2, 1'b0, 32'h0000_1008, 32'h0, 4'h0, rd, e, cyc);
    chk("rst_old_word", rd, 32'h1234_5678);
    chk("rst_idle_latency", 32'(cyc), 32'd5);

    // Fields changing after capture must not disturb the in-flight request.
    valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h0000_100C; wdata[2] = 32'hCAFE_F00D; wstrb[2] = 4'hF;
    @(posedge clk); #1;
    valid[2] = 1'b0; we[2] = 1'b0; addr[2] = 32'h0000_1010; wdata[2] = 32'h0; wstrb[2] = 4'h0;
    cyc = 0;
    e = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready[2] && cyc == 0) begin
        cyc = k; e = err[2];
      end
    end
    chk("viol_latency", 32'(cyc), 32'd4);
    chk("viol_err", {31'h0, e}, 32'h0);
    @(posedge clk); #1;
    txn(2, 1'b0, 32'h0000_100C, 32'h0, 4'h0, rd, e, cyc);
    chk("viol_data", rd, 32'hCAFE_F00D);

    // Random traffic against a word model on the LATENCY=1 instance.
    for (int i = 0; i < 1024; i++) begin
      if (i < 20 || i >= 1020) begin
        mdl[i] = $urandom;
        txn(0, 1'b1, 32'h0000_1000 + 32'(i * 4), mdl[i], 4'hF, rd, e, cyc);
      end
    end
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a, d, idx, exp_rd;
      logic        w, inr;
      logic [3:0]  s;
      a = ($urandom_range(0, 3) == 0) ? 32'h0000_1FF0 + 32'($urandom_range(0, 31))
                                      : 32'h0000_0FF0 + 32'($urandom_range(0, 95));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      inr = (a >= 32'h0000_1000) && (a < 32'h0000_2000);
      idx = (a - 32'h0000_1000) >> 2;
      exp_rd = (!w && inr) ? mdl[idx[9:0]] : 32'h0;
      if (w && inr) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mdl[idx[9:0]][8*b +: 8] = d[8*b +: 8];
        end
      end
      txn(0, w, a, d, s, rd, e, cyc);
      chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      chk($sformatf("rnd%0d_err", t), {31'h0, e}, {31'h0, ~inr});
      chk($sformatf("rnd%0d_latency", t), 32'(cyc), 32'd3);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
